idiv_sequencer: RTL and testbench

Multi-cycle integer divide/remainder sequencer for the RV32M DIV/DIVU/REM/REMU group. It is triggered by the IDiv flag that the IALU control decoder raises for R-type instructions with Funct7_0=1 and Funct3[2]=1. It holds the pipeline with Stall while a radix-2 restoring divide iterates, applies RISC-V sign, divide-by-zero and overflow rules, and returns a single-cycle Done with the result. It sits beside the IALU in the execute stage; its result is muxed onto the IALU result path when Done=1.

---
 rtl/idiv_sequencer.sv | 137 +++++++++++++
 tb/tb_idiv_sequencer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/idiv_sequencer.sv
// Multi-cycle radix-2 restoring divide/remainder sequencer for DIV/DIVU/REM/REMU.
// Optional early-out for |divisor| > |dividend| when IDIV_EARLY_OUT_EN is defined.
module idiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IDiv,
  input  logic [2:0]      Funct3,
  input  logic            Flush,
  input  logic [XLEN-1:0] Rs1,
  input  logic [XLEN-1:0] Rs2,
  output logic            Stall,
  output logic            Done,
  output logic [XLEN-1:0] Result
);

  // state | meaning
  // IDLE  | waiting for IDiv
  // CALC  | one restoring-divide iteration per cycle
  // FIX   | sign correction, Result load
  // DONE  | Done pulse, pipeline released
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(XLEN-1);

  state_t state, state_nxt;

  logic [XLEN-1:0]  quo, rem, divisor;
  logic [CNT_W-1:0] cnt;
  logic             op_rem, neg_q, neg_r;

  logic             start, is_signed, div_zero, ovf, early;
  logic [XLEN-1:0]  a_mag, b_mag, q_fix, r_fix;
  logic [XLEN:0]    trial;
  logic             unused_f3;

  assign unused_f3 = Funct3[2];

  assign start     = (state == IDLE) & IDiv & ~Flush & ~RST;
  assign is_signed = ~Funct3[0];
  assign a_mag     = (is_signed & Rs1[XLEN-1]) ? -Rs1 : Rs1;
  assign b_mag     = (is_signed & Rs2[XLEN-1]) ? -Rs2 : Rs2;
  assign div_zero  = (Rs2 == '0);
  assign ovf       = is_signed & (Rs1 == MIN_NEG) & (Rs2 == '1);

`ifdef IDIV_EARLY_OUT_EN
  assign early = (b_mag > a_mag);
`else
  assign early = 1'b0;
`endif

  // Trial subtract on the shifted partial remainder; the extra bit keeps the shifted value exact.
  assign trial = {rem, quo[XLEN-1]} - {1'b0, divisor};
  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem : rem;

  assign Stall = start | (state == CALC) | (state == FIX);
  assign Done  = (state == DONE) & ~Flush;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (div_zero || ovf) state_nxt = DONE;
          else if (early)      state_nxt = FIX;
          else                 state_nxt = CALC;
        end
      end
      CALC: begin
        if (Flush)               state_nxt = IDLE;
        else if (cnt == LAST_IT) state_nxt = FIX;
      end
      FIX:     state_nxt = Flush ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      quo     <= '0;
      rem     <= '0;
      divisor <= '0;
      cnt     <= '0;
      op_rem  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      Result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_rem  <= Funct3[1];
            neg_q   <= is_signed & (Rs1[XLEN-1] ^ Rs2[XLEN-1]);
            neg_r   <= is_signed & Rs1[XLEN-1];
            divisor <= b_mag;
            quo     <= a_mag;
            rem     <= '0;
            cnt     <= '0;
            if (div_zero)  Result <= Funct3[1] ? Rs1 : '1;
            else if (ovf)  Result <= Funct3[1] ? '0 : Rs1;
            else if (early) begin
              quo <= '0;
              rem <= a_mag;
            end
          end
        end
        CALC: begin
          if (!Flush) begin
            if (!trial[XLEN]) begin
              rem <= trial[XLEN-1:0];
              quo <= {quo[XLEN-2:0], 1'b1};
            end else begin
              rem <= {rem[XLEN-2:0], quo[XLEN-1]};
              quo <= {quo[XLEN-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (!Flush) Result <= op_rem ? r_fix : q_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_idiv_sequencer.sv
// Directed bench for idiv_sequencer: latency, Stall window, special cases, Flush and reset.
module tb_idiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, idiv, flush;
  logic [2:0]  f3;
  logic [31:0] rs1, rs2;
  logic        stall, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

`ifdef IDIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  idiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .CLK(clk), .RST(rst), .IDiv(idiv), .Funct3(f3), .Flush(flush),
    .Rs1(rs1), .Rs2(rs2), .Stall(stall), .Done(done), .Result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one op (called #1 after a rising edge), hold IDiv until Done, check result/latency/Stall.
  task automatic run_op(input string tag, input logic [2:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input int lat);
    int cyc = 0;
    int nstall = 0;
    bit seen = 0;
    f3 = fn; rs1 = a; rs2 = b; idiv = 1'b1;
    while (!seen && cyc <= 60) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({tag, "_stall_at_done"}, 32'(stall), 32'd0);
        chk({tag, "_result"}, result, res);
        chk({tag, "_latency"}, 32'(cyc), 32'(lat));
      end else begin
        if (stall) nstall++;
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else       chk({tag, "_stall_cycles"}, 32'(nstall), 32'(lat));
    @(posedge clk); #1;
    idiv = 1'b0; f3 = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
  endtask

  initial begin
    int ndone, nstall;
    rst = 1'b1; idiv = 1'b0; flush = 1'b0; f3 = 3'b000; rs1 = 32'h0; rs2 = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("div_20_m3", F_DIV, 32'd20, 32'hFFFFFFFD, 32'hFFFFFFFA, 34);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;

    run_op("rem_m20_3",   F_REM,  32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, 34);
    run_op("remu_m20_3",  F_REMU, 32'hFFFFFFEC, 32'd3, 32'h00000002, 34);
    run_op("divu_z",      F_DIVU, 32'h1234, 32'h0, 32'hFFFFFFFF, 1);
    run_op("remu_z",      F_REMU, 32'h1234, 32'h0, 32'h00001234, 1);
    run_op("rem_m5_z",    F_REM,  32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 1);
    run_op("div_ovf",     F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",     F_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run_op("div_m7_2",    F_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
    run_op("rem_m7_2",    F_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
    run_op("divu_max_1",  F_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 34);
    run_op("divu_3_7",    F_DIVU, 32'd3, 32'd7, 32'h0, EO_LAT);
    run_op("remu_3_7",    F_REMU, 32'd3, 32'd7, 32'd3, EO_LAT);
    run_op("rem_m3_7",    F_REM,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFD, EO_LAT);

    // Flush mid-CALC: no Done, Stall drops, Result keeps the previous value
    f3 = F_DIVU; rs1 = 32'd100; rs2 = 32'd7; idiv = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall_c10", 32'(stall), 32'd1);
    chk("flush_done_c10", 32'(done), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; idiv = 1'b0;
    ndone = 0; nstall = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) ndone++;
      if (stall) nstall++;
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_no_stall", 32'(nstall), 32'd0);
    chk("flush_result_held", result, 32'hFFFFFFFD);
    @(posedge clk); #1;
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 34);

    // Async reset in CALC cycle 15 with IDiv still asserted
    f3 = F_DIV; rs1 = 32'd1000; rs2 = 32'd3; idiv = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", result, 32'h0);
    @(posedge clk); #1;
    idiv = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    run_op("div_7_2", F_DIV, 32'd7, 32'd2, 32'd3, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
